// File: rtl/adpll_lock_detect.sv
// ADPLL lock detector: per-ref-window phase error and control-code stability, debounced lock flag.
// Optional lock-loss event counter is built when ADPLL_LOCK_LOSS_CNT_EN is defined.

module adpll_lock_detect #(
    parameter int unsigned ERR_W      = 16,
    parameter int unsigned ERR_TOL    = 1200,
    parameter int unsigned CODE_TOL   = 1,
    parameter int unsigned LOCK_CNT   = 8,
    parameter int unsigned UNLOCK_CNT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ref_clk,
    input  logic             fb_clk,
    input  logic [3:0]       vco_code,
    output logic             locked,
    output logic             lock_lost,
    output logic             err_valid,
    output logic [ERR_W-1:0] phase_err,
    output logic [7:0]       loss_count
);

    localparam logic [ERR_W-1:0] CntMax = '1;
    localparam logic [ERR_W-1:0] CntOne = {{(ERR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StAcq, StLock, StHold} state_e;

    logic [2:0]       ref_sync_q, fb_sync_q;
    logic [3:0]       code_meta_q, code_now_q;
    logic             ref_rise, fb_rise;

    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] fb_off_q, fb_off_d;
    logic             fb_seen_q, fb_seen_d;
    logic [1:0]       fb_edges_q, fb_edges_d;
    logic [3:0]       code_prev_q, code_prev_d;

    logic [ERR_W-1:0] fb_lag, err_min, err;
    logic [3:0]       code_delta;
    logic             good, eval;

    state_e           state_q, state_d;
    logic [7:0]       good_cnt_q, good_cnt_d;
    logic [7:0]       bad_cnt_q, bad_cnt_d;
    logic             locked_q, locked_d;
    logic             lock_lost_q, lost_d;
    logic             err_valid_q;
    logic [ERR_W-1:0] phase_err_q;
    logic             drop;

    // Two synchroniser stages plus one edge-detect stage per async input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_sync_q  <= '0;
            fb_sync_q   <= '0;
            code_meta_q <= '0;
            code_now_q  <= '0;
        end else begin
            ref_sync_q  <= {ref_sync_q[1:0], ref_clk};
            fb_sync_q   <= {fb_sync_q[1:0], fb_clk};
            code_meta_q <= vco_code;
            code_now_q  <= code_meta_q;
        end
    end

    assign ref_rise = ref_sync_q[1] & ~ref_sync_q[2];
    assign fb_rise  = fb_sync_q[1] & ~fb_sync_q[2];

    always_comb begin
        cnt_d       = cnt_q;
        fb_off_d    = fb_off_q;
        fb_seen_d   = fb_seen_q;
        fb_edges_d  = fb_edges_q;
        code_prev_d = code_prev_q;
        if (ref_rise) begin
            // A coincident fb edge opens the new window at offset 0.
            cnt_d       = CntOne;
            code_prev_d = code_now_q;
            fb_off_d    = '0;
            fb_seen_d   = fb_rise;
            fb_edges_d  = {1'b0, fb_rise};
        end else begin
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + CntOne;
            end
            if (fb_rise) begin
                if (!fb_seen_q) begin
                    fb_off_d  = cnt_q;
                    fb_seen_d = 1'b1;
                end
                if (fb_edges_q != 2'd3) begin
                    fb_edges_d = fb_edges_q + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            fb_off_q    <= '0;
            fb_seen_q   <= 1'b0;
            fb_edges_q  <= '0;
            code_prev_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            fb_off_q    <= fb_off_d;
            fb_seen_q   <= fb_seen_d;
            fb_edges_q  <= fb_edges_d;
            code_prev_q <= code_prev_d;
        end
    end

    // Phase error is the shorter way round the window, so a lag near a full period reads small.
    assign fb_lag     = cnt_q - fb_off_q;
    assign err_min    = (fb_off_q < fb_lag) ? fb_off_q : fb_lag;
    assign err        = fb_seen_q ? err_min : CntMax;
    assign code_delta = (code_now_q >= code_prev_q) ? (code_now_q - code_prev_q)
                                                    : (code_prev_q - code_now_q);
    assign good = (fb_edges_q == 2'd1) && (cnt_q != CntMax) && (32'(err) <= ERR_TOL) &&
                  (32'(code_delta) <= CODE_TOL);
    assign eval = ref_rise && (state_q != StIdle);

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        locked_d   = locked_q;
        lost_d     = 1'b0;
        drop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ref_rise) state_d = StAcq;
            end
            StAcq: begin
                if (ref_rise) begin
                    if (!good) begin
                        good_cnt_d = '0;
                    end else if (32'(good_cnt_q) + 32'd1 >= LOCK_CNT) begin
                        state_d    = StLock;
                        locked_d   = 1'b1;
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + 8'd1;
                    end
                end
            end
            StLock: begin
                if (ref_rise) begin
                    if (!good) begin
                        if (UNLOCK_CNT <= 1) begin
                            drop = 1'b1;
                        end else begin
                            state_d   = StHold;
                            bad_cnt_d = 8'd1;
                        end
                    end
                end else if (cnt_q == CntMax) begin
                    drop = 1'b1;
                end
            end
            StHold: begin
                if (ref_rise) begin
                    if (good) begin
                        state_d   = StLock;
                        bad_cnt_d = '0;
                    end else if (32'(bad_cnt_q) + 32'd1 >= UNLOCK_CNT) begin
                        drop = 1'b1;
                    end else begin
                        bad_cnt_d = bad_cnt_q + 8'd1;
                    end
                end else if (cnt_q == CntMax) begin
                    drop = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (drop) begin
            state_d    = StAcq;
            locked_d   = 1'b0;
            lost_d     = 1'b1;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
            err_valid_q <= 1'b0;
            phase_err_q <= '0;
        end else begin
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            locked_q    <= locked_d;
            lock_lost_q <= lost_d;
            err_valid_q <= eval;
            if (eval) phase_err_q <= err;
        end
    end

    assign locked    = locked_q;
    assign lock_lost = lock_lost_q;
    assign err_valid = err_valid_q;
    assign phase_err = phase_err_q;

`ifdef ADPLL_LOCK_LOSS_CNT_EN
    logic [7:0] loss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_q <= '0;
        end else if (lost_d && (loss_cnt_q != 8'hff)) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign loss_count = loss_cnt_q;
`else
    assign loss_count = '0;
`endif

endmodule
